// File: rtl/vga_timing.sv
// vga_timing: parametrised VGA raster timing generator.
// Produces sync, blanking, active-select and raw x/y counters, advancing one
// pixel per pix_en. Line/frame start strobes mark entry to x==0 / (0,0).
// Timing is reprogrammable through a small config write channel. Writes land
// in staging registers, and a commit is applied at the next frame boundary
// after validation.
//
// Optional feature macro: VGA_TIMING_RASTER_IRQ_EN. When it is defined, an
// irq_line register and a raster-line irq strobe are built.
//
// Ports:
//   aclk, aresetn          clock, asynchronous active-low reset
//   pix_en                 advance one pixel on this edge
//   hsync, vsync           sync at configured polarity
//   hblank, vblank         outside horizontal/vertical active region
//   select                 active video
//   x, y                   raw pixel/line counters
//   line_start/frame_start one-cycle strobes on entry to x==0 / (0,0)
//   cfg_valid/cfg_ready    config write handshake
//   cfg_sel/cfg_data       0..7 staging fields, 8 commit, 9 irq line
//   cfg_err                one-cycle strobe: commit rejected
//   irq                    raster-line strobe
module vga_timing #(
    parameter int unsigned WIDTH    = 12,
    parameter int unsigned H_ACTIVE = 640,
    parameter int unsigned H_FRONT  = 16,
    parameter int unsigned H_SYNC   = 96,
    parameter int unsigned H_BACK   = 48,
    parameter int unsigned V_ACTIVE = 480,
    parameter int unsigned V_FRONT  = 10,
    parameter int unsigned V_SYNC   = 2,
    parameter int unsigned V_BACK   = 33,
    parameter logic        HSYNC_POL = 1'b0,
    parameter logic        VSYNC_POL = 1'b0
) (
    input  logic             aclk,
    input  logic             aresetn,
    input  logic             pix_en,
    output logic             hsync,
    output logic             vsync,
    output logic             hblank,
    output logic             vblank,
    output logic             select,
    output logic [WIDTH-1:0] x,
    output logic [WIDTH-1:0] y,
    output logic             line_start,
    output logic             frame_start,
    input  logic             cfg_valid,
    output logic             cfg_ready,
    input  logic [3:0]       cfg_sel,
    input  logic [WIDTH-1:0] cfg_data,
    output logic             cfg_err,
    output logic             irq
);

    // Totals need two extra bits: four WIDTH-bit fields can sum past 2^WIDTH.
    localparam int unsigned TW = WIDTH + 2;
    localparam logic [TW-1:0] LIMIT = TW'(1) << WIDTH;

    // Field index order: h_active, h_front, h_sync, h_back, v_active, v_front, v_sync, v_back.
    logic [WIDTH-1:0] live  [8];
    logic [WIDTH-1:0] stage [8];

    function automatic logic [WIDTH-1:0] rst_val(input int unsigned i);
        case (i)
            0:       return WIDTH'(H_ACTIVE);
            1:       return WIDTH'(H_FRONT);
            2:       return WIDTH'(H_SYNC);
            3:       return WIDTH'(H_BACK);
            4:       return WIDTH'(V_ACTIVE);
            5:       return WIDTH'(V_FRONT);
            6:       return WIDTH'(V_SYNC);
            default: return WIDTH'(V_BACK);
        endcase
    endfunction

    function automatic logic [TW-1:0] sum4(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                                           input logic [WIDTH-1:0] c, input logic [WIDTH-1:0] d);
        return TW'(a) + TW'(b) + TW'(c) + TW'(d);
    endfunction

    logic [TW-1:0]    h_total, v_total, sh_total, sv_total;
    logic             x_last, y_last, apply, stage_ok, apply_ok, xfer;
    logic [WIDTH-1:0] nx, ny;
    logic [WIDTH-1:0] d_ha, d_hf, d_hs, d_va, d_vf, d_vs;
    logic [TW-1:0]    hs_start, hs_end, vs_start, vs_end;
    logic             n_hsync, n_vsync;

    // Next position, commit validation and decode of the next position.
    always_comb begin
        h_total  = sum4(live[0], live[1], live[2], live[3]);
        v_total  = sum4(live[4], live[5], live[6], live[7]);
        sh_total = sum4(stage[0], stage[1], stage[2], stage[3]);
        sv_total = sum4(stage[4], stage[5], stage[6], stage[7]);
        x_last   = (TW'(x) == h_total - TW'(1));
        y_last   = (TW'(y) == v_total - TW'(1));
        xfer     = cfg_valid && cfg_ready;
        // A pending commit is exactly the state where cfg_ready is low.
        apply    = pix_en && x_last && y_last && !cfg_ready;
        stage_ok = (stage[0] != '0) && (stage[2] != '0) && (stage[4] != '0) && (stage[6] != '0)
                   && (sh_total <= LIMIT) && (sv_total <= LIMIT);
        apply_ok = apply && stage_ok;
        nx = x_last ? '0 : x + WIDTH'(1);
        ny = y;
        if (x_last) begin
            ny = y_last ? '0 : y + WIDTH'(1);
        end
        // The first position of a newly committed frame decodes with the new timing.
        d_ha = apply_ok ? stage[0] : live[0];
        d_hf = apply_ok ? stage[1] : live[1];
        d_hs = apply_ok ? stage[2] : live[2];
        d_va = apply_ok ? stage[4] : live[4];
        d_vf = apply_ok ? stage[5] : live[5];
        d_vs = apply_ok ? stage[6] : live[6];
        hs_start = TW'(d_ha) + TW'(d_hf);
        hs_end   = hs_start + TW'(d_hs);
        vs_start = TW'(d_va) + TW'(d_vf);
        vs_end   = vs_start + TW'(d_vs);
        n_hsync  = ((TW'(nx) >= hs_start) && (TW'(nx) < hs_end)) ? HSYNC_POL : !HSYNC_POL;
        n_vsync  = ((TW'(ny) >= vs_start) && (TW'(ny) < vs_end)) ? VSYNC_POL : !VSYNC_POL;
    end

    // Counters, registered decode outputs and strobes.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            x           <= '0;
            y           <= '0;
            hsync       <= !HSYNC_POL;
            vsync       <= !VSYNC_POL;
            hblank      <= 1'b0;
            vblank      <= 1'b0;
            select      <= 1'b1;
            line_start  <= 1'b0;
            frame_start <= 1'b0;
            cfg_err     <= 1'b0;
        end else begin
            line_start  <= 1'b0;
            frame_start <= 1'b0;
            cfg_err     <= apply && !stage_ok;
            if (pix_en) begin
                x           <= nx;
                y           <= ny;
                hsync       <= n_hsync;
                vsync       <= n_vsync;
                hblank      <= (nx >= d_ha);
                vblank      <= (ny >= d_va);
                select      <= (nx < d_ha) && (ny < d_va);
                line_start  <= (nx == '0);
                frame_start <= (nx == '0) && (ny == '0);
            end
        end
    end

    // Staging/live timing registers and the commit handshake.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            for (int i = 0; i < 8; i++) begin
                live[i]  <= rst_val(i);
                stage[i] <= rst_val(i);
            end
            cfg_ready <= 1'b1;
        end else begin
            if (xfer && !cfg_sel[3]) begin
                stage[cfg_sel[2:0]] <= cfg_data;
            end
            if (apply_ok) begin
                for (int i = 0; i < 8; i++) begin
                    live[i] <= stage[i];
                end
            end
            if (apply) begin
                cfg_ready <= 1'b1;
            end else if (xfer && (cfg_sel == 4'd8)) begin
                cfg_ready <= 1'b0;
            end
        end
    end

`ifdef VGA_TIMING_RASTER_IRQ_EN
    logic [WIDTH-1:0] irq_line;

    // Raster-line interrupt fires alongside line_start on the selected line.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            irq_line <= '0;
            irq      <= 1'b0;
        end else begin
            if (xfer && (cfg_sel == 4'd9)) begin
                irq_line <= cfg_data;
            end
            irq <= pix_en && (nx == '0) && (ny == irq_line);
        end
    end
`else
    assign irq = 1'b0;
`endif

endmodule

// File: tb/tb_vga_timing.sv
// Bench for vga_timing using a reduced raster so whole frames fit in a short run:
// H 10/2/3/5 (total 20), V 4/1/2/1 (total 8), hsync active-high, vsync active-low.
// Stimulus pushes hand-computed expectations tagged with the cycle at which
// they must hold. A separate monitor pops and compares them each cycle.
// Flag order: {hsync, vsync, hblank, vblank, select, line_start, frame_start, cfg_err, cfg_ready, irq}
module tb_vga_timing;

    localparam int unsigned W = 8;
`ifdef VGA_TIMING_RASTER_IRQ_EN
    localparam logic IRQ = 1'b1;
`else
    localparam logic IRQ = 1'b0;
`endif

    logic         aclk = 1'b0;
    logic         aresetn;
    logic         pix_en;
    logic         hsync, vsync, hblank, vblank, select, line_start, frame_start;
    logic [W-1:0] x, y;
    logic         cfg_valid, cfg_ready, cfg_err, irq;
    logic [3:0]   cfg_sel;
    logic [W-1:0] cfg_data;

    vga_timing #(
        .WIDTH(W),
        .H_ACTIVE(10), .H_FRONT(2), .H_SYNC(3), .H_BACK(5),
        .V_ACTIVE(4),  .V_FRONT(1), .V_SYNC(2), .V_BACK(1),
        .HSYNC_POL(1'b1), .VSYNC_POL(1'b0)
    ) dut (
        .aclk(aclk), .aresetn(aresetn), .pix_en(pix_en),
        .hsync(hsync), .vsync(vsync), .hblank(hblank), .vblank(vblank),
        .select(select), .x(x), .y(y),
        .line_start(line_start), .frame_start(frame_start),
        .cfg_valid(cfg_valid), .cfg_ready(cfg_ready), .cfg_sel(cfg_sel),
        .cfg_data(cfg_data), .cfg_err(cfg_err), .irq(irq)
    );

    always #5 aclk = ~aclk;

    typedef struct packed {
        logic [31:0]  cyc;
        logic [127:0] name;
        logic         tmo;
        logic [W-1:0] ex;
        logic [W-1:0] ey;
        logic [9:0]   fl;
    } exp_t;

    exp_t sb[$];
    int   cyc   = 0;
    int   total = 0;
    int   bad   = 0;

    always @(posedge aclk) cyc <= cyc + 1;

    // Monitor: compare every expectation due at or before this cycle.
    always @(negedge aclk) begin
        exp_t e;
        logic [9:0] act;
        act = {hsync, vsync, hblank, vblank, select, line_start, frame_start, cfg_err, cfg_ready, irq};
        while (sb.size() > 0 && int'(sb[0].cyc) <= cyc) begin
            e = sb.pop_front();
            total++;
            if (e.tmo) begin
                bad++;
                $display("FAIL %s: cfg_ready wait timed out, got 0 want 1", e.name);
            end else if (int'(e.cyc) != cyc || x != e.ex || y != e.ey || act != e.fl) begin
                bad++;
                $display("FAIL %s: cyc=%0d got x=%0d y=%0d flags=%b, want cyc=%0d x=%0d y=%0d flags=%b",
                         e.name, cyc, x, y, act, e.cyc, e.ex, e.ey, e.fl);
            end
        end
    end

    task automatic expect_at(input int k, input logic [127:0] nm, input int ex, input int ey,
                             input logic [9:0] fl);
        exp_t e;
        e.cyc = 32'(cyc + k); e.name = nm; e.tmo = 1'b0;
        e.ex = W'(ex); e.ey = W'(ey); e.fl = fl;
        sb.push_back(e);
    endtask

    task automatic run(input int n, input logic en);
        for (int i = 0; i < n; i++) begin
            pix_en = en;
            @(posedge aclk); #1;
        end
        pix_en = 1'b0;
    endtask

    task automatic cfg_write(input logic [3:0] sel, input int data);
        int w;
        exp_t e;
        w = 0;
        while (!cfg_ready && w < 100) begin
            @(posedge aclk); #1;
            w++;
        end
        if (!cfg_ready) begin
            e = '0; e.cyc = 32'(cyc); e.name = "cfg_wait"; e.tmo = 1'b1;
            sb.push_back(e);
        end
        cfg_valid = 1'b1; cfg_sel = sel; cfg_data = W'(data);
        @(posedge aclk); #1;
        cfg_valid = 1'b0;
    endtask

    initial begin
        aresetn = 1'b0; pix_en = 1'b0; cfg_valid = 1'b0; cfg_sel = '0; cfg_data = '0;
        @(posedge aclk); #1;
        expect_at(0, "reset", 0, 0, 10'b0_1_0_0_1_0_0_0_1_0);
        @(posedge aclk); #1;
        aresetn = 1'b1;
        expect_at(2, "rel_hold", 0, 0, 10'b0_1_0_0_1_0_0_0_1_0);
        run(2, 1'b0);

        // Default timing, pix_en continuous.
        expect_at(1,   "d_x1",    1, 0,  10'b0_1_0_0_1_0_0_0_1_0);
        expect_at(10,  "d_hblk",  10, 0, 10'b0_1_1_0_0_0_0_0_1_0);
        expect_at(12,  "d_hs_on", 12, 0, 10'b1_1_1_0_0_0_0_0_1_0);
        expect_at(14,  "d_hs_in", 14, 0, 10'b1_1_1_0_0_0_0_0_1_0);
        expect_at(15,  "d_hs_off",15, 0, 10'b0_1_1_0_0_0_0_0_1_0);
        expect_at(19,  "d_xlast", 19, 0, 10'b0_1_1_0_0_0_0_0_1_0);
        expect_at(20,  "d_line1", 0, 1,  10'b0_1_0_0_1_1_0_0_1_0);
        expect_at(21,  "d_ls_end",1, 1,  10'b0_1_0_0_1_0_0_0_1_0);
        expect_at(80,  "d_vblk",  0, 4,  10'b0_1_0_1_0_1_0_0_1_0);
        expect_at(100, "d_vs_on", 0, 5,  10'b0_0_0_1_0_1_0_0_1_0);
        expect_at(140, "d_vs_off",0, 7,  10'b0_1_0_1_0_1_0_0_1_0);
        expect_at(160, "d_frame", 0, 0,  {9'b0_1_0_0_1_1_1_0_1, IRQ});
        expect_at(161, "d_fs_end",1, 0,  10'b0_1_0_0_1_0_0_0_1_0);
        run(161, 1'b1);

        // pix_en every other cycle: outputs hold on disabled cycles.
        expect_at(1,  "h_hold",  1, 0,  10'b0_1_0_0_1_0_0_0_1_0);
        expect_at(2,  "h_step",  2, 0,  10'b0_1_0_0_1_0_0_0_1_0);
        expect_at(3,  "h_hold2", 2, 0,  10'b0_1_0_0_1_0_0_0_1_0);
        expect_at(37, "h_x19",   19, 0, 10'b0_1_1_0_0_0_0_0_1_0);
        expect_at(38, "h_line",  0, 1,  10'b0_1_0_0_1_1_0_0_1_0);
        expect_at(39, "h_ls_1cy",0, 1,  10'b0_1_0_0_1_0_0_0_1_0);
        for (int i = 1; i <= 40; i++) begin
            pix_en = (i % 2 == 0);
            @(posedge aclk); #1;
        end
        pix_en = 1'b0;

        // Mid-frame reprogram to 8x6, raster irq line 2, then commit.
        cfg_write(4'd0, 4); cfg_write(4'd1, 1); cfg_write(4'd2, 2); cfg_write(4'd3, 1);
        cfg_write(4'd4, 3); cfg_write(4'd5, 1); cfg_write(4'd6, 1); cfg_write(4'd7, 1);
        cfg_write(4'd9, 2);
        cfg_write(4'd8, 0);
        expect_at(0,   "c_rdy_lo", 1, 1,  10'b0_1_0_0_1_0_0_0_0_0);
        expect_at(1,   "c_old1",   2, 1,  10'b0_1_0_0_1_0_0_0_0_0);
        expect_at(19,  "c_old_l2", 0, 2,  {9'b0_1_0_0_1_1_0_0_0, IRQ});
        expect_at(138, "c_oldend", 19, 7, 10'b0_1_1_1_0_0_0_0_0_0);
        expect_at(139, "c_new00",  0, 0,  10'b0_1_0_0_1_1_1_0_1_0);
        expect_at(140, "c_x1",     1, 0,  10'b0_1_0_0_1_0_0_0_1_0);
        expect_at(143, "c_hblk",   4, 0,  10'b0_1_1_0_0_0_0_0_1_0);
        expect_at(144, "c_hs_on",  5, 0,  10'b1_1_1_0_0_0_0_0_1_0);
        expect_at(146, "c_hs_off", 7, 0,  10'b0_1_1_0_0_0_0_0_1_0);
        expect_at(147, "c_line1",  0, 1,  10'b0_1_0_0_1_1_0_0_1_0);
        expect_at(155, "c_irq_l2", 0, 2,  {9'b0_1_0_0_1_1_0_0_1, IRQ});
        expect_at(163, "c_vblk",   0, 3,  10'b0_1_0_1_0_1_0_0_1_0);
        expect_at(171, "c_vs_on",  0, 4,  10'b0_0_0_1_0_1_0_0_1_0);
        expect_at(179, "c_vs_off", 0, 5,  10'b0_1_0_1_0_1_0_0_1_0);
        expect_at(187, "c_frame48",0, 0,  10'b0_1_0_0_1_1_1_0_1_0);
        expect_at(188, "c_x1b",    1, 0,  10'b0_1_0_0_1_0_0_0_1_0);
        run(188, 1'b1);

        // Commit with h_sync = 0 is rejected at the frame end.
        cfg_write(4'd2, 0);
        cfg_write(4'd8, 0);
        expect_at(0,  "e_rdy_lo", 1, 0,  10'b0_1_0_0_1_0_0_0_0_0);
        expect_at(46, "e_end",    7, 5,  10'b0_1_1_1_0_0_0_0_0_0);
        expect_at(47, "e_err",    0, 0,  10'b0_1_0_0_1_1_1_1_1_0);
        expect_at(48, "e_err_1cy",1, 0,  10'b0_1_0_0_1_0_0_0_1_0);
        expect_at(54, "e_keep_x7",7, 0,  10'b0_1_1_0_0_0_0_0_1_0);
        expect_at(55, "e_keep_l1",0, 1,  10'b0_1_0_0_1_1_0_0_1_0);
        run(55, 1'b1);

        // Horizontal total of 257 exceeds 2^WIDTH: rejected.
        cfg_write(4'd0, 253);
        cfg_write(4'd2, 2);
        cfg_write(4'd8, 0);
        expect_at(0,  "o_rdy_lo", 0, 1,  10'b0_1_0_0_1_0_0_0_0_0);
        expect_at(40, "o_err",    0, 0,  10'b0_1_0_0_1_1_1_1_1_0);
        expect_at(41, "o_keep",   1, 0,  10'b0_1_0_0_1_0_0_0_1_0);
        run(41, 1'b1);

        // Horizontal total of exactly 256 is accepted and wraps at x=255.
        cfg_write(4'd0, 252);
        cfg_write(4'd8, 0);
        expect_at(0,   "m_rdy_lo", 1, 0,   10'b0_1_0_0_1_0_0_0_0_0);
        expect_at(47,  "m_new00",  0, 0,   10'b0_1_0_0_1_1_1_0_1_0);
        expect_at(48,  "m_x1",     1, 0,   10'b0_1_0_0_1_0_0_0_1_0);
        expect_at(299, "m_hblk",   252, 0, 10'b0_1_1_0_0_0_0_0_1_0);
        expect_at(300, "m_hs_on",  253, 0, 10'b1_1_1_0_0_0_0_0_1_0);
        expect_at(302, "m_x255",   255, 0, 10'b0_1_1_0_0_0_0_0_1_0);
        expect_at(303, "m_wrap",   0, 1,   10'b0_1_0_0_1_1_0_0_1_0);
        run(303, 1'b1);

        // Reset mid-frame with a commit pending.
        expect_at(10, "r_pos",     10, 1, 10'b0_1_0_0_1_0_0_0_1_0);
        run(10, 1'b1);
        cfg_write(4'd0, 5);
        cfg_write(4'd8, 0);
        expect_at(0, "r_pending",  10, 1, 10'b0_1_0_0_1_0_0_0_0_0);
        @(posedge aclk); #1;
        aresetn = 1'b0;
        expect_at(0, "r_async",    0, 0,  10'b0_1_0_0_1_0_0_0_1_0);
        run(2, 1'b0);
        aresetn = 1'b1;
        expect_at(1,   "r_x1",     1, 0,  10'b0_1_0_0_1_0_0_0_1_0);
        expect_at(5,   "r_x5",     5, 0,  10'b0_1_0_0_1_0_0_0_1_0);
        expect_at(10,  "r_hblk",   10, 0, 10'b0_1_1_0_0_0_0_0_1_0);
        expect_at(20,  "r_line1",  0, 1,  10'b0_1_0_0_1_1_0_0_1_0);
        expect_at(160, "r_frame",  0, 0,  {9'b0_1_0_0_1_1_1_0_1, IRQ});
        expect_at(165, "r_nocommit",5, 0, 10'b0_1_0_0_1_0_0_0_1_0);
        run(165, 1'b1);

        @(negedge aclk);
        @(negedge aclk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
